// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader writing big-endian words into instruction memory
module prog_loader #(
    parameter int unsigned                  ADDR_WIDTH = 18,
    parameter logic [ADDR_WIDTH-1:0]        BASE_ADDR  = '0,
    parameter int unsigned                  MAX_WORDS  = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            byte_data,
    input  logic                  byte_valid,
    output logic                  byte_ready,
    input  logic                  restart,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           words_loaded
);

    typedef enum logic [2:0] {
        S_CNT_HI, S_CNT_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t                  state_q;
    logic [15:0]             count_q;
    logic [23:0]             shift_q;
    logic [1:0]              bcnt_q;
    logic [7:0]              xor_q;
    logic                    imem_we_q;
    logic [ADDR_WIDTH-1:0]   imem_addr_q;
    logic [31:0]             imem_wdata_q;
    logic                    cpu_hold_q;
    logic                    done_q;
    logic                    error_q;
    logic [15:0]             words_loaded_q;

    logic                    accept;
    logic [15:0]             count_d;
    logic [15:0]             words_d;
    logic [ADDR_WIDTH-1:0]   write_addr;

    assign byte_ready = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                        (state_q == S_DATA)   || (state_q == S_CHECK);
    assign accept     = byte_valid && byte_ready;
    assign count_d    = {count_q[15:8], byte_data};
    assign words_d    = words_loaded_q + 16'd1;
    // Address arithmetic wraps at ADDR_WIDTH; legal MAX_WORDS keeps it in range.
    assign write_addr = BASE_ADDR + ADDR_WIDTH'({words_loaded_q, 2'b00});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_CNT_HI;
            count_q        <= '0;
            shift_q        <= '0;
            bcnt_q         <= '0;
            xor_q          <= '0;
            imem_we_q      <= 1'b0;
            imem_addr_q    <= BASE_ADDR;
            imem_wdata_q   <= '0;
            cpu_hold_q     <= 1'b1;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            imem_we_q <= 1'b0;
            // The checksum byte itself is excluded from the running XOR.
            if (accept && state_q != S_CHECK) begin
                xor_q <= xor_q ^ byte_data;
            end
            case (state_q)
                S_CNT_HI: begin
                    if (accept) begin
                        count_q[15:8] <= byte_data;
                        state_q       <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (accept) begin
                        count_q[7:0] <= byte_data;
                        if (32'(count_d) > MAX_WORDS) begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end else if (count_d == 16'd0) begin
                            state_q <= S_CHECK;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        bcnt_q  <= bcnt_q + 2'd1;
                        shift_q <= {shift_q[15:0], byte_data};
                        if (bcnt_q == 2'd3) begin
                            state_q      <= S_WRITE;
                            imem_we_q    <= 1'b1;
                            imem_addr_q  <= write_addr;
                            imem_wdata_q <= {shift_q, byte_data};
                        end
                    end
                end
                S_WRITE: begin
                    words_loaded_q <= words_d;
                    state_q        <= (words_d == count_q) ? S_CHECK : S_DATA;
                end
                S_CHECK: begin
                    if (accept) begin
                        if (byte_data == xor_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            error_q <= 1'b1;
                        end
                    end
                end
                S_DONE, S_ERROR: begin
                    if (restart) begin
                        state_q        <= S_CNT_HI;
                        done_q         <= 1'b0;
                        error_q        <= 1'b0;
                        cpu_hold_q     <= 1'b1;
                        words_loaded_q <= '0;
                        xor_q          <= '0;
                        bcnt_q         <= '0;
                    end
                end
                default: state_q <= S_CNT_HI;
            endcase
        end
    end

    assign imem_we      = imem_we_q;
    assign imem_addr    = imem_addr_q;
    assign imem_wdata   = imem_wdata_q;
    assign cpu_hold     = cpu_hold_q;
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule
